mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports iREN (in, 1, fetch read request) and iaddr (in, 32, fetch word address).
REQ-004 SHALL have ports iload (out, 32, fetch data) and ihit (out, 1, fetch complete).
REQ-005 SHALL have ports dREN (in, 1), dWEN (in, 1), daddr (in, 32) and dstore (in, 32); these are the data-side request.
REQ-006 SHALL have ports dload (out, 32) and dhit (out, 1, data access complete).
REQ-007 SHALL have ports ramREN (out, 1), ramWEN (out, 1), ramaddr (out, 32) and ramstore (out, 32); these form the shared RAM port.
REQ-008 SHALL have ports ramload (in, 32) and ramstate (in, 2): FREE=00, BUSY=01, ACCESS=10, ERROR=11.
REQ-009 SHALL have port err (out, 1), a one-cycle pulse on RAM error.
REQ-010 SHALL have ports istall_cnt and dstall_cnt (out, 32 each), the stall statistics.

Function
REQ-011 SHALL implement an FSM with states IDLE, IGNT and DGNT.
REQ-012 In IDLE, with a data request (dREN|dWEN), the next state SHALL be DGNT; else with iREN, IGNT; else IDLE; a starvation override applies per REQ-017.
REQ-013 In IDLE, all ram* request outputs and both hits SHALL be 0, and ramaddr/ramstore SHALL be 0.
REQ-014 In IGNT, ramREN SHALL be iREN and ramaddr SHALL be iaddr.
REQ-015 In DGNT, the ram* outputs SHALL follow the data request: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore; write wins if both are set.
REQ-016 In IGNT/DGNT with ramstate==ACCESS, the matching hit SHALL be asserted combinationally that cycle, and iload/dload SHALL pass ramload.
  - next state IDLE (one idle turnaround cycle per access)
REQ-017 Starvation guard: a 3-bit streak counter SHALL count consecutive DGNT completions while iREN was pending at completion.
  - when streak==4 and iREN is pending in IDLE: grant IGNT regardless of data request
  - streak clears on any IGNT completion, or on a DGNT completion with iREN low
REQ-018 Abort: if the granted requester deasserts its request in IGNT/DGNT before ACCESS, the FSM SHALL return to IDLE next cycle with no hit; the streak is unchanged.
REQ-019 In IGNT/DGNT with ramstate==ERROR, the FSM SHALL:
  - pulse err for that cycle
  - assert no hit
  - go to IDLE
  - leave the streak unchanged
REQ-020 ramstate FREE/BUSY in a grant state SHALL hold the state and hold the outputs.
REQ-021 iload/dload SHALL be 0 whenever the corresponding hit is 0.
REQ-022 ihit and dhit SHALL never be asserted in the same cycle.

Reset
REQ-023 RST high at a clock edge SHALL force, from the next cycle:
  - state IDLE
  - streak 0
  - istall_cnt and dstall_cnt 0
  - all outputs to their IDLE values
REQ-024 Reset SHALL take priority over any in-flight grant; an interrupted access SHALL produce no hit and no err.

Configuration
REQ-025 Macro MEM_ARB_STATS_EN SHALL control the stall counters.
REQ-026 With MEM_ARB_STATS_EN defined, the counters SHALL update each cycle:
  - istall_cnt increments when iREN=1 and ihit=0
  - dstall_cnt increments when (dREN|dWEN)=1 and dhit=0
  - both counters wrap modulo 2^32
REQ-027 Without MEM_ARB_STATS_EN, istall_cnt and dstall_cnt SHALL be constant 0, no counter registers SHALL be synthesized, and the ports SHALL remain.

Verification
REQ-028 Fetch read: in IDLE, iREN=1, iaddr=0x40, ramstate goes ACCESS on the 3rd cycle with ramload=0xDEADBEEF -> ihit=1 for exactly that cycle, iload=0xDEADBEEF, then IDLE.
REQ-029 Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0x5) in IDLE -> DGNT first, ramWEN=1, ramaddr=0x100, ramstore=0x5, dhit on ACCESS; then IGNT serves the fetch.
REQ-030 Starvation: iREN held, dREN re-asserted every access, ACCESS after 1 cycle each -> exactly 4 dhits, then an ihit, then the streak restarts.
REQ-031 Error/abort:
  - ramstate=ERROR in DGNT -> err=1 one cycle, dhit=0, IDLE next
  - iREN dropped mid-IGNT -> IDLE, no ihit
REQ-032 Reset mid-access: RST=1 during DGNT with ramstate=ACCESS on the following cycle -> no dhit, state IDLE, counters 0.
REQ-033 Stats (macro defined): iREN held 5 cycles with the hit on the 5th -> istall_cnt=4; with the macro undefined -> istall_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single RAM port, data-priority with a fetch
// starvation guard. Define MEM_ARB_STATS_EN to build the stall-statistics counters.
module mem_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err,
    output logic [31:0] istall_cnt,
    output logic [31:0] dstall_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StIgnt = 2'd1;
    localparam logic [1:0] StDgnt = 2'd2;

    localparam logic [1:0] RamAccess = 2'b10;
    localparam logic [1:0] RamError  = 2'b11;

    localparam logic [2:0] StreakMax = 3'd4;

    logic [1:0] state_q, state_d;
    logic [2:0] streak_q, streak_d;
    logic       dreq;

    assign dreq = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = 32'd0;
        dload    = 32'd0;
        err      = 1'b0;
        case (state_q)
            StIdle: begin
                if (streak_q == StreakMax && iREN) state_d = StIgnt;
                else if (dreq)                     state_d = StDgnt;
                else if (iREN)                     state_d = StIgnt;
            end
            StIgnt: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = StIdle;
                end else if (ramstate == RamAccess) begin
                    ihit     = 1'b1;
                    iload    = ramload;
                    state_d  = StIdle;
                    streak_d = 3'd0;
                end else if (ramstate == RamError) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end
            end
            StDgnt: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = StIdle;
                end else if (ramstate == RamAccess) begin
                    dhit    = 1'b1;
                    dload   = ramload;
                    state_d = StIdle;
                    // Saturate so a dropped-then-restored fetch cannot push past the threshold.
                    if (!iREN)                  streak_d = 3'd0;
                    else if (streak_q != StreakMax) streak_d = streak_q + 3'd1;
                end else if (ramstate == RamError) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // An access interrupted by reset must not report completion or error.
        if (RST) begin
            ihit  = 1'b0;
            dhit  = 1'b0;
            iload = 32'd0;
            dload = 32'd0;
            err   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            streak_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] istall_q, dstall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            istall_q <= 32'd0;
            dstall_q <= 32'd0;
        end else begin
            if (iREN && !ihit) istall_q <= istall_q + 32'd1;
            if (dreq && !dhit) dstall_q <= dstall_q + 32'd1;
        end
    end

    assign istall_cnt = istall_q;
    assign dstall_cnt = dstall_q;
`else
    assign istall_cnt = 32'd0;
    assign dstall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, simultaneous requests, starvation guard,
// error/abort, reset mid-access and stall statistics.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore, istall_cnt, dstall_cnt;
    logic        ihit, dhit, ramREN, ramWEN, err;

    int checks = 0;
    int errors = 0;

`ifdef MEM_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    localparam logic [1:0] Free   = 2'b00;
    localparam logic [1:0] Busy   = 2'b01;
    localparam logic [1:0] Access = 2'b10;
    localparam logic [1:0] Error  = 2'b11;

    mem_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iload      (iload),
        .ihit       (ihit),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .dload      (dload),
        .dhit       (dhit),
        .ramREN     (ramREN),
        .ramWEN     (ramWEN),
        .ramaddr    (ramaddr),
        .ramstore   (ramstore),
        .ramload    (ramload),
        .ramstate   (ramstate),
        .err        (err),
        .istall_cnt (istall_cnt),
        .dstall_cnt (dstall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = Free;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ihit", ihit, 0);
        check("rst_dhit", dhit, 0);
        check("rst_err", err, 0);
        check("rst_istall", istall_cnt, 0);
        check("rst_dstall", dstall_cnt, 0);

        // Fetch read, ACCESS on the 3rd cycle
        iREN = 1; iaddr = 32'h40; ramstate = Free; #1;
        check("f_idle_ramREN", ramREN, 0);
        check("f_idle_ihit", ihit, 0);
        tick();
        ramstate = Busy; #1;
        check("f_busy_ramREN", ramREN, 1);
        check("f_busy_ramaddr", ramaddr, 32'h40);
        check("f_busy_ihit", ihit, 0);
        check("f_busy_iload", iload, 0);
        tick();
        ramstate = Access; ramload = 32'hDEADBEEF; #1;
        check("f_acc_ihit", ihit, 1);
        check("f_acc_iload", iload, 32'hDEADBEEF);
        check("f_acc_dhit", dhit, 0);
        tick();
        iREN = 0; ramstate = Free; #1;
        check("f_after_ihit", ihit, 0);
        check("f_after_iload", iload, 0);
        check("f_after_ramREN", ramREN, 0);
        check("f_istall", istall_cnt, StatsEn ? 32'd2 : 32'd0);

        // Simultaneous requests: data first, then fetch
        do_reset();
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'h5; #1;
        check("s_idle_ramWEN", ramWEN, 0);
        tick();
        dREN = 1; ramstate = Access; ramload = 32'h1234; #1;
        check("s_d_ramWEN", ramWEN, 1);
        check("s_d_ramREN_wwins", ramREN, 0);
        check("s_d_ramaddr", ramaddr, 32'h100);
        check("s_d_ramstore", ramstore, 32'h5);
        check("s_d_dhit", dhit, 1);
        check("s_d_dload", dload, 32'h1234);
        check("s_d_ihit", ihit, 0);
        tick();
        dREN = 0; dWEN = 0; ramstate = Free; #1;
        check("s_idle2_dhit", dhit, 0);
        check("s_idle2_ramWEN", ramWEN, 0);
        check("s_idle2_ramstore", ramstore, 0);
        tick();
        ramstate = Access; ramload = 32'hCAFE; #1;
        check("s_i_ihit", ihit, 1);
        check("s_i_iload", iload, 32'hCAFE);
        check("s_i_ramaddr", ramaddr, 32'h44);
        check("s_i_dhit", dhit, 0);
        check("s_i_dload", dload, 0);
        tick();
        iREN = 0; ramstate = Free;

        // Starvation guard: four data hits, then a forced fetch, then data again
        do_reset();
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300; ramload = 32'h77;
        for (int k = 0; k < 4; k++) begin
            ramstate = Free; #1;
            check("st_idle_dhit", dhit, 0);
            tick();
            ramstate = Access; #1;
            check("st_dhit", dhit, 1);
            check("st_ihit_low", ihit, 0);
            tick();
        end
        ramstate = Free; #1;
        check("st_idle5_dhit", dhit, 0);
        tick();
        ramstate = Access; #1;
        check("st_forced_ihit", ihit, 1);
        check("st_forced_dhit", dhit, 0);
        check("st_forced_ramaddr", ramaddr, 32'h80);
        tick();
        ramstate = Free; #1;
        tick();
        ramstate = Access; #1;
        check("st_restart_dhit", dhit, 1);
        check("st_restart_ihit", ihit, 0);
        tick();
        iREN = 0; dREN = 0; ramstate = Free;

        // Error in DGNT
        do_reset();
        dREN = 1; daddr = 32'h200; #1;
        tick();
        ramstate = Busy; #1;
        check("e_busy_ramREN", ramREN, 1);
        check("e_busy_err", err, 0);
        check("e_busy_dhit", dhit, 0);
        tick();
        ramstate = Error; ramload = 32'h55; #1;
        check("e_err", err, 1);
        check("e_dhit", dhit, 0);
        check("e_dload", dload, 0);
        tick();
        dREN = 0; ramstate = Free; #1;
        check("e_after_err", err, 0);
        check("e_after_ramREN", ramREN, 0);
        check("e_dstall", dstall_cnt, StatsEn ? 32'd3 : 32'd0);

        // Abort: iREN dropped mid-IGNT
        iREN = 1; iaddr = 32'h90; #1;
        tick();
        ramstate = Busy; #1;
        check("a_busy_ramREN", ramREN, 1);
        tick();
        iREN = 0; #1;
        check("a_drop_ihit", ihit, 0);
        check("a_drop_ramREN", ramREN, 0);
        tick();
        iREN = 1; ramstate = Access; #1;
        check("a_idle_ihit", ihit, 0);
        check("a_idle_ramREN", ramREN, 0);
        tick();
        #1;
        check("a_regrant_ihit", ihit, 1);
        tick();
        iREN = 0; ramstate = Free;

        // Reset mid-access
        do_reset();
        dREN = 1; daddr = 32'h400; #1;
        tick();
        RST = 1; ramstate = Busy; #1;
        check("r_rstcyc_ramREN", ramREN, 1);
        tick();
        RST = 0; ramstate = Access; #1;
        check("r_dhit", dhit, 0);
        check("r_ramREN", ramREN, 0);
        check("r_err", err, 0);
        check("r_dstall", dstall_cnt, 0);
        check("r_istall", istall_cnt, 0);
        dREN = 0;

        // Stats: iREN held 5 cycles, hit on the 5th
        do_reset();
        iREN = 1; iaddr = 32'hA0; #1;
        tick();
        for (int k = 0; k < 3; k++) begin
            ramstate = Busy; #1;
            tick();
        end
        ramstate = Access; #1;
        check("x_ihit", ihit, 1);
        tick();
        iREN = 0; ramstate = Free; #1;
        check("x_istall", istall_cnt, StatsEn ? 32'd4 : 32'd0);
        check("x_dstall", dstall_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
